// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the five-stage pipelined CPU.
//   XLEN, RAW   : datapath width and register-address width
//   ALU_*       : 4-bit ALU opcodes understood by the ALU's alucon input
//   idex_t      : bundle of every field carried across the ID/EX boundary
// ---------------------------------------------------------------------------
package cpu_pkg;

   localparam int XLEN = 32;
   localparam int RAW  = 5;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SLL  = 4'd1;
   localparam logic [3:0] ALU_SLT  = 4'd2;
   localparam logic [3:0] ALU_SLTU = 4'd3;
   localparam logic [3:0] ALU_XOR  = 4'd4;
   localparam logic [3:0] ALU_SRL  = 4'd5;
   localparam logic [3:0] ALU_OR   = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_SUB  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd13;

   // Everything ID hands to EX for one instruction.
   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] rs1_data;
      logic [XLEN-1:0] rs2_data;
      logic [XLEN-1:0] imm;
      logic [RAW-1:0]  rs1;
      logic [RAW-1:0]  rs2;
      logic [RAW-1:0]  rd;
      logic [3:0]      alucon;
      logic            alusrc_a;
      logic            alusrc_b;
      logic            regwrite;
      logic            memread;
      logic            memwrite;
   } idex_t;

endpackage

// File: rtl/fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
// Picks the freshest value of one source register for the EX stage.
//   src                  : source register number held in ID/EX
//   stored               : operand value captured into ID/EX
//   exmem_* / memwb_*    : write-back intent of the two younger stages
//   value                : selected operand
// The instruction in EX/MEM is newer than the one in MEM/WB, so it wins when
// both target the same register. x0 is hard-wired to zero and never forwarded.
// ---------------------------------------------------------------------------
module fwd_mux #(
   parameter int XLEN = 32,
   parameter int RAW  = 5
) (
   input  logic [RAW-1:0]  src,
   input  logic [XLEN-1:0] stored,
   input  logic            exmem_regwrite,
   input  logic [RAW-1:0]  exmem_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_regwrite,
   input  logic [RAW-1:0]  memwb_rd,
   input  logic [XLEN-1:0] memwb_result,
   output logic [XLEN-1:0] value
);

   logic exmem_hit;
   logic memwb_hit;

   assign exmem_hit = exmem_regwrite && (exmem_rd != '0) && (exmem_rd == src);
   assign memwb_hit = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == src);

   // Later assignment wins, so EX/MEM overrides MEM/WB.
   always_comb begin
      value = stored;
      if (memwb_hit) value = memwb_result;
      if (exmem_hit) value = exmem_result;
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ---------------------------------------------------------------------------
// ex_operand_stage
// ID/EX pipeline register plus operand forwarding and load-use detection.
//   clk, rst             : clock and synchronous active-high reset
//   id_*                 : decoded instruction fields from ID
//   flush                : redirect; the instruction entering EX is killed
//   exmem_* / memwb_*    : forwarding sources from the younger stages
//   stall_id             : load-use stall request to PC and IF/ID
//   ex_in1/ex_in2/ex_alucon : straight into the ALU
//   ex_store_data        : forwarded rs2 for stores
//   ex_pc, ex_rd, ex_valid, ex_regwrite/memread/memwrite : EX instruction info
// ---------------------------------------------------------------------------
module ex_operand_stage #(
   parameter int XLEN = cpu_pkg::XLEN,
   parameter int RAW  = cpu_pkg::RAW
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            id_valid,
   input  logic [XLEN-1:0] id_pc,
   input  logic [XLEN-1:0] id_rs1_data,
   input  logic [XLEN-1:0] id_rs2_data,
   input  logic [XLEN-1:0] id_imm,
   input  logic [RAW-1:0]  id_rs1,
   input  logic [RAW-1:0]  id_rs2,
   input  logic [RAW-1:0]  id_rd,
   input  logic [3:0]      id_alucon,
   input  logic            id_alusrc_a,
   input  logic            id_alusrc_b,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            id_memwrite,
   input  logic            flush,
   input  logic            exmem_regwrite,
   input  logic [RAW-1:0]  exmem_rd,
   input  logic [XLEN-1:0] exmem_result,
   input  logic            memwb_regwrite,
   input  logic [RAW-1:0]  memwb_rd,
   input  logic [XLEN-1:0] memwb_result,
   output logic            stall_id,
   output logic            ex_valid,
   output logic [XLEN-1:0] ex_in1,
   output logic [XLEN-1:0] ex_in2,
   output logic [3:0]      ex_alucon,
   output logic [XLEN-1:0] ex_store_data,
   output logic [XLEN-1:0] ex_pc,
   output logic [RAW-1:0]  ex_rd,
   output logic            ex_regwrite,
   output logic            ex_memread,
   output logic            ex_memwrite
);

   import cpu_pkg::*;

   logic [XLEN-1:0] rs1_val;
   logic [XLEN-1:0] rs2_val;
   logic [XLEN-1:0] imm_val;
   logic [RAW-1:0]  rs1_num;
   logic [RAW-1:0]  rs2_num;
   logic            sel_pc;
   logic            sel_imm;
   logic            regwrite_bit;
   logic            memread_bit;
   logic            memwrite_bit;

   logic            wt_rs1;
   logic            wt_rs2;
   logic [XLEN-1:0] fwd_rs1;
   logic [XLEN-1:0] fwd_rs2;

   // The register file is written at the end of the cycle, so a WB to the
   // register ID is reading right now would be missed; take it directly.
   assign wt_rs1 = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_rs1);
   assign wt_rs2 = memwb_regwrite && (memwb_rd != '0) && (memwb_rd == id_rs2);

   // A load in EX has no data yet; anything in ID that reads its target must
   // wait one cycle. The rs2 compare is made even when rs2 is unused.
   assign stall_id = ex_valid && memread_bit && (ex_rd != '0) && id_valid &&
                     ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));

   // Reset, flush and stall all load the same all-zero bubble (alucon = ADD,
   // rs numbers = x0 so nothing forwards into it); otherwise capture ID.
   always_ff @(posedge clk) begin
      if (rst || flush || stall_id) begin
         ex_valid     <= 1'b0;
         ex_pc        <= '0;
         rs1_val      <= '0;
         rs2_val      <= '0;
         imm_val      <= '0;
         rs1_num      <= '0;
         rs2_num      <= '0;
         ex_rd        <= '0;
         ex_alucon    <= ALU_ADD;
         sel_pc       <= 1'b0;
         sel_imm      <= 1'b0;
         regwrite_bit <= 1'b0;
         memread_bit  <= 1'b0;
         memwrite_bit <= 1'b0;
      end else begin
         ex_valid     <= id_valid;
         ex_pc        <= id_pc;
         rs1_val      <= wt_rs1 ? memwb_result : id_rs1_data;
         rs2_val      <= wt_rs2 ? memwb_result : id_rs2_data;
         imm_val      <= id_imm;
         rs1_num      <= id_rs1;
         rs2_num      <= id_rs2;
         ex_rd        <= id_rd;
         ex_alucon    <= id_alucon;
         sel_pc       <= id_alusrc_a;
         sel_imm      <= id_alusrc_b;
         regwrite_bit <= id_regwrite;
         memread_bit  <= id_memread;
         memwrite_bit <= id_memwrite;
      end
   end

   fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs1 (
      .src            (rs1_num),
      .stored         (rs1_val),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .value          (fwd_rs1)
   );

   fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd_rs2 (
      .src            (rs2_num),
      .stored         (rs2_val),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .value          (fwd_rs2)
   );

   assign ex_in1        = sel_pc  ? ex_pc   : fwd_rs1;
   assign ex_in2        = sel_imm ? imm_val : fwd_rs2;
   assign ex_store_data = fwd_rs2;

   assign ex_regwrite = ex_valid && regwrite_bit;
   assign ex_memread  = ex_valid && memread_bit;
   assign ex_memwrite = ex_valid && memwrite_bit;

endmodule

// File: tb/tb_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// tb_ex_operand_stage
// Directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a behavioural model of the ID/EX stage.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
// ---------------------------------------------------------------------------
module tb_ex_operand_stage;

   import cpu_pkg::*;

   logic            clk;
   logic            rst;
   logic            id_valid;
   logic [XLEN-1:0] id_pc;
   logic [XLEN-1:0] id_rs1_data;
   logic [XLEN-1:0] id_rs2_data;
   logic [XLEN-1:0] id_imm;
   logic [RAW-1:0]  id_rs1;
   logic [RAW-1:0]  id_rs2;
   logic [RAW-1:0]  id_rd;
   logic [3:0]      id_alucon;
   logic            id_alusrc_a;
   logic            id_alusrc_b;
   logic            id_regwrite;
   logic            id_memread;
   logic            id_memwrite;
   logic            flush;
   logic            exmem_regwrite;
   logic [RAW-1:0]  exmem_rd;
   logic [XLEN-1:0] exmem_result;
   logic            memwb_regwrite;
   logic [RAW-1:0]  memwb_rd;
   logic [XLEN-1:0] memwb_result;
   logic            stall_id;
   logic            ex_valid;
   logic [XLEN-1:0] ex_in1;
   logic [XLEN-1:0] ex_in2;
   logic [3:0]      ex_alucon;
   logic [XLEN-1:0] ex_store_data;
   logic [XLEN-1:0] ex_pc;
   logic [RAW-1:0]  ex_rd;
   logic            ex_regwrite;
   logic            ex_memread;
   logic            ex_memwrite;

   int vectors;
   int miscompares;

   // Model of what the ID/EX register must hold right now.
   idex_t model;

   ex_operand_stage #(.XLEN(XLEN), .RAW(RAW)) dut (
      .clk            (clk),
      .rst            (rst),
      .id_valid       (id_valid),
      .id_pc          (id_pc),
      .id_rs1_data    (id_rs1_data),
      .id_rs2_data    (id_rs2_data),
      .id_imm         (id_imm),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_rd          (id_rd),
      .id_alucon      (id_alucon),
      .id_alusrc_a    (id_alusrc_a),
      .id_alusrc_b    (id_alusrc_b),
      .id_regwrite    (id_regwrite),
      .id_memread     (id_memread),
      .id_memwrite    (id_memwrite),
      .flush          (flush),
      .exmem_regwrite (exmem_regwrite),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_regwrite (memwb_regwrite),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .stall_id       (stall_id),
      .ex_valid       (ex_valid),
      .ex_in1         (ex_in1),
      .ex_in2         (ex_in2),
      .ex_alucon      (ex_alucon),
      .ex_store_data  (ex_store_data),
      .ex_pc          (ex_pc),
      .ex_rd          (ex_rd),
      .ex_regwrite    (ex_regwrite),
      .ex_memread     (ex_memread),
      .ex_memwrite    (ex_memwrite)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // One comparison; every check in the bench funnels through here.
   task automatic checkValue(input string name, input logic [XLEN-1:0] actual,
                             input logic [XLEN-1:0] expected);
      vectors++;
      if (actual !== expected) begin
         miscompares++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                  name, actual, expected, $time);
      end
   endtask

   // Most recent value a reader of register r would see from the younger stages.
   function automatic logic [XLEN-1:0] freshest(input logic [RAW-1:0] r,
                                                input logic [XLEN-1:0] held);
      if (r == 0) return held;
      if (exmem_regwrite && exmem_rd == r) return exmem_result;
      if (memwb_regwrite && memwb_rd == r) return memwb_result;
      return held;
   endfunction

   function automatic logic expectStall();
      return model.valid && model.memread && (model.rd != 0) && id_valid &&
             (id_rs1 == model.rd || id_rs2 == model.rd);
   endfunction

   // Compare every DUT output against the model for the current inputs.
   task automatic checkOutput();
      logic [XLEN-1:0] op1, op2;
      op1 = freshest(model.rs1, model.rs1_data);
      op2 = freshest(model.rs2, model.rs2_data);
      checkValue("stall_id",    XLEN'(stall_id),    XLEN'(expectStall()));
      checkValue("ex_valid",    XLEN'(ex_valid),    XLEN'(model.valid));
      checkValue("ex_in1",      ex_in1,             model.alusrc_a ? model.pc : op1);
      checkValue("ex_in2",      ex_in2,             model.alusrc_b ? model.imm : op2);
      checkValue("ex_store",    ex_store_data,      op2);
      checkValue("ex_alucon",   XLEN'(ex_alucon),   XLEN'(model.alucon));
      checkValue("ex_pc",       ex_pc,              model.pc);
      checkValue("ex_rd",       XLEN'(ex_rd),       XLEN'(model.rd));
      checkValue("ex_regwrite", XLEN'(ex_regwrite), XLEN'(model.valid & model.regwrite));
      checkValue("ex_memread",  XLEN'(ex_memread),  XLEN'(model.valid & model.memread));
      checkValue("ex_memwrite", XLEN'(ex_memwrite), XLEN'(model.valid & model.memwrite));
   endtask

   // What the register holds after the coming rising edge.
   task automatic modelClock();
      idex_t nxt;
      nxt = '0;
      if (!(rst || flush || expectStall())) begin
         nxt.valid    = id_valid;
         nxt.pc       = id_pc;
         nxt.imm      = id_imm;
         nxt.rs1      = id_rs1;
         nxt.rs2      = id_rs2;
         nxt.rd       = id_rd;
         nxt.alucon   = id_alucon;
         nxt.alusrc_a = id_alusrc_a;
         nxt.alusrc_b = id_alusrc_b;
         nxt.regwrite = id_regwrite;
         nxt.memread  = id_memread;
         nxt.memwrite = id_memwrite;
         nxt.rs1_data = (memwb_regwrite && memwb_rd != 0 && memwb_rd == id_rs1)
                        ? memwb_result : id_rs1_data;
         nxt.rs2_data = (memwb_regwrite && memwb_rd != 0 && memwb_rd == id_rs2)
                        ? memwb_result : id_rs2_data;
      end
      model = nxt;
   endtask

   // Inputs have been set after a falling edge: check, advance model, clock.
   task automatic applyStimulus();
      #1;
      checkOutput();
      modelClock();
      @(negedge clk);
   endtask

   task automatic setIdle();
      rst = 0; flush = 0;
      id_valid = 0; id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
      id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_alucon = 0;
      id_alusrc_a = 0; id_alusrc_b = 0;
      id_regwrite = 0; id_memread = 0; id_memwrite = 0;
      exmem_regwrite = 0; exmem_rd = 0; exmem_result = 0;
      memwb_regwrite = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   task automatic randomId();
      id_valid    = ($urandom_range(0, 3) != 0);
      id_pc       = $urandom;
      id_rs1_data = $urandom;
      id_rs2_data = $urandom;
      id_imm      = $urandom;
      id_rs1      = RAW'($urandom_range(0, 3));
      id_rs2      = RAW'($urandom_range(0, 3));
      id_rd       = RAW'($urandom_range(0, 3));
      id_alucon   = 4'($urandom);
      id_alusrc_a = 1'($urandom);
      id_alusrc_b = 1'($urandom);
      id_regwrite = 1'($urandom);
      id_memread  = ($urandom_range(0, 2) == 0);
      id_memwrite = 1'($urandom);
   endtask

   task automatic randomFwd();
      exmem_regwrite = 1'($urandom);
      exmem_rd       = RAW'($urandom_range(0, 3));
      exmem_result   = $urandom;
      memwb_regwrite = 1'($urandom);
      memwb_rd       = RAW'($urandom_range(0, 3));
      memwb_result   = $urandom;
   endtask

   task automatic loadX3();
      setIdle();
      id_valid = 1; id_pc = 32'h100; id_rs1 = 1; id_rd = 3;
      id_memread = 1; id_regwrite = 1; id_alusrc_b = 1; id_imm = 8;
   endtask

   task automatic addX4X3X1();
      setIdle();
      id_valid = 1; id_pc = 32'h104; id_rs1 = 3; id_rs2 = 1; id_rd = 4;
      id_rs1_data = 32'h7777; id_rs2_data = 32'h11; id_regwrite = 1;
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      model = '0;
      setIdle();
      @(negedge clk);

      // Reset held two cycles with garbage in ID.
      for (int i = 0; i < 2; i++) begin
         randomId();
         rst = 1;
         applyStimulus();
      end
      setIdle();
      #1;
      checkValue("rst_valid", XLEN'(ex_valid), 0);
      checkValue("rst_in1",   ex_in1, 0);
      checkValue("rst_in2",   ex_in2, 0);
      checkValue("rst_store", ex_store_data, 0);
      checkValue("rst_pc",    ex_pc, 0);
      checkValue("rst_stall", XLEN'(stall_id), 0);
      applyStimulus();

      // sub x6,x5,x5 with stale data, x5 produced by the instruction in EX/MEM.
      id_valid = 1; id_rs1 = 5; id_rs2 = 5; id_rd = 6; id_alucon = ALU_SUB;
      id_rs1_data = 32'h99; id_rs2_data = 32'h99; id_regwrite = 1;
      applyStimulus();
      setIdle();
      exmem_regwrite = 1; exmem_rd = 5; exmem_result = 32'h10;
      #1;
      checkValue("exmem_in1",    ex_in1, 32'h10);
      checkValue("exmem_in2",    ex_in2, 32'h10);
      checkValue("exmem_alucon", XLEN'(ex_alucon), 8);
      applyStimulus();

      // Both younger stages write x7: EX/MEM must win; x0 never forwards.
      setIdle();
      id_valid = 1; id_rs1 = 7; id_rs2 = 7; id_rd = 10;
      id_rs1_data = 32'h55; id_rs2_data = 32'h66;
      applyStimulus();
      setIdle();
      exmem_regwrite = 1; exmem_rd = 7; exmem_result = 32'hAAAA;
      memwb_regwrite = 1; memwb_rd = 7; memwb_result = 32'hBBBB;
      #1;
      checkValue("prio_in1",   ex_in1, 32'hAAAA);
      checkValue("prio_store", ex_store_data, 32'hAAAA);
      exmem_rd = 0;
      #1;
      checkValue("memwb_in1", ex_in1, 32'hBBBB);
      memwb_rd = 0;
      #1;
      checkValue("x0_in1", ex_in1, 32'h55);
      checkValue("x0_in2", ex_in2, 32'h66);
      applyStimulus();

      // Load-use: one bubble, then the consumer picks up the load from MEM/WB.
      loadX3();
      applyStimulus();
      addX4X3X1();
      #1;
      checkValue("lu_stall", XLEN'(stall_id), 1);
      applyStimulus();
      #1;
      checkValue("lu_stall_drop", XLEN'(stall_id), 0);
      checkValue("lu_bubble",     XLEN'(ex_valid), 0);
      applyStimulus();
      setIdle();
      memwb_regwrite = 1; memwb_rd = 3; memwb_result = 32'hCAFE;
      #1;
      checkValue("lu_valid", XLEN'(ex_valid), 1);
      checkValue("lu_rd",    XLEN'(ex_rd), 4);
      checkValue("lu_in1",   ex_in1, 32'hCAFE);
      applyStimulus();

      // Flush and stall together: bubble, then normal capture resumes.
      loadX3();
      applyStimulus();
      addX4X3X1();
      flush = 1;
      #1;
      checkValue("fl_stall", XLEN'(stall_id), 1);
      applyStimulus();
      setIdle();
      id_valid = 1; id_rd = 8; id_regwrite = 1; id_alusrc_b = 1; id_imm = 3;
      #1;
      checkValue("fl_valid",    XLEN'(ex_valid), 0);
      checkValue("fl_regwrite", XLEN'(ex_regwrite), 0);
      applyStimulus();
      setIdle();
      #1;
      checkValue("fl_resume_rw", XLEN'(ex_regwrite), 1);
      checkValue("fl_resume_rd", XLEN'(ex_rd), 8);
      applyStimulus();

      // Write-through: addi x2,x9,4 while WB writes x9.
      id_valid = 1; id_rs1 = 9; id_rd = 2; id_rs1_data = 0;
      id_alusrc_b = 1; id_imm = 4; id_regwrite = 1;
      memwb_regwrite = 1; memwb_rd = 9; memwb_result = 32'h1234;
      applyStimulus();
      setIdle();
      #1;
      checkValue("wt_in1", ex_in1, 32'h1234);
      checkValue("wt_in2", ex_in2, 4);
      applyStimulus();

      // Reset during a stall clears EX and drops the stall with it.
      loadX3();
      applyStimulus();
      addX4X3X1();
      rst = 1;
      applyStimulus();
      addX4X3X1();
      #1;
      checkValue("rs_stall", XLEN'(stall_id), 0);
      checkValue("rs_valid", XLEN'(ex_valid), 0);
      applyStimulus();

      // Randomized traffic against the model.
      for (int i = 0; i < 600; i++) begin
         randomId();
         randomFwd();
         rst   = ($urandom_range(0, 63) == 0);
         flush = ($urandom_range(0, 7) == 0);
         applyStimulus();
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/ex_operand_stage.md
# ex_operand_stage

ID/EX pipeline register and operand-forwarding stage that feeds the 32-bit ALU in the five-stage pipelined CPU. It captures decoded instruction fields from ID each cycle, resolves RAW hazards by forwarding from EX/MEM and MEM/WB, and detects load-use hazards, stalling ID and inserting a bubble. Its outputs `ex_in1`, `ex_in2` and `ex_alucon` connect directly to the ALU's `in1`, `in2` and `alucon` inputs.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `RAW`, 5: register address width.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `id_valid` in 1: ID holds a real instruction.
- `id_pc`, `id_rs1_data`, `id_rs2_data`, `id_imm` in XLEN each: PC, register-file read data, sign-extended immediate.
- `id_rs1`, `id_rs2`, `id_rd` in RAW each: source and destination register numbers.
- `id_alucon` in 4: ALU opcode.
- `id_alusrc_a` in 1: 0 selects forwarded rs1, 1 selects PC.
- `id_alusrc_b` in 1: 0 selects forwarded rs2, 1 selects immediate.
- `id_regwrite`, `id_memread`, `id_memwrite` in 1 each: control bits.
- `flush` in 1: branch/jump redirect; kill the instruction entering EX.
- `exmem_regwrite` in 1, `exmem_rd` in RAW, `exmem_result` in XLEN: EX/MEM forwarding source.
- `memwb_regwrite` in 1, `memwb_rd` in RAW, `memwb_result` in XLEN: MEM/WB forwarding source.
- `stall_id` out 1: load-use stall; PC and IF/ID must hold.
- `ex_valid` out 1: EX holds a real instruction.
- `ex_in1`, `ex_in2` out XLEN each: ALU operands.
- `ex_alucon` out 4: ALU opcode.
- `ex_store_data` out XLEN: forwarded rs2 value, for stores.
- `ex_pc` out XLEN: PC of the EX instruction.
- `ex_rd` out RAW: destination register of the EX instruction.
- `ex_regwrite`, `ex_memread`, `ex_memwrite` out 1 each: control bits, already qualified by `ex_valid`.

## Operation
Registered update, evaluated in this priority order:
1. **`rst`**: clear all registered fields to 0, including `ex_valid`.
2. **`flush`**: load a bubble.
3. **`stall_id`**: load a bubble.
4. **Otherwise**: capture all `id_*` fields; `ex_valid` takes `id_valid`.

Bubble:
- Clears `ex_valid`, `ex_regwrite`, `ex_memread`, `ex_memwrite`, `ex_rd` and the stored rs1/rs2 numbers.
- Sets `ex_alucon` to 0 (ADD).
- Data fields are don't-care; they are cleared to 0.

Write-through on capture:
- If `memwb_regwrite` is set, `memwb_rd` != 0 and `memwb_rd` == `id_rs1`, store `memwb_result` instead of `id_rs1_data`. Same rule for rs2.
- This covers the register-file write/read in the same cycle.

Forwarding, combinational from the stored rs1 number (same rule for rs2):
- EX/MEM match (`exmem_regwrite`, `exmem_rd` != 0, `exmem_rd` == stored rs1): use `exmem_result`.
- Else MEM/WB match (same conditions on `memwb_*`): use `memwb_result`.
- Else use the stored data.
- EX/MEM wins when both match.
- Register x0 is never forwarded.

Operand select:
- `ex_in1` = `id_alusrc_a` (stored) ? `ex_pc` : forwarded rs1.
- `ex_in2` = `id_alusrc_b` (stored) ? stored immediate : forwarded rs2.
- `ex_store_data` is always forwarded rs2, regardless of `alusrc_b`.

Load-use detection, combinational:
- `stall_id` = `ex_valid` & `ex_memread` & (`ex_rd` != 0) & `id_valid` & (`id_rs1` == `ex_rd` | `id_rs2` == `ex_rd`).
- The rs2 compare is made even for I-type instructions. This is conservative and acceptable.
- `stall_id` is not gated by `flush`. When both are high, `flush` selects the bubble and ID is redirected anyway.

## Timing
- ID to EX latency: 1 cycle.
- All `ex_*` outputs are valid in the cycle after capture.
- `ex_in1`, `ex_in2` and `ex_store_data` are combinational from the registers and the forwarding inputs. There is no extra latency; the path is register → mux → ALU.
- Load-use: exactly one bubble per hazard. The next cycle the load sits in MEM, so `stall_id` drops and the consumer's data arrives later via MEM/WB.
- Reset values:
  - `ex_valid`, `ex_regwrite`, `ex_memread`, `ex_memwrite`: 0.
  - `ex_rd`, `ex_pc`, `ex_alucon`: 0.
  - `ex_in1`, `ex_in2`, `ex_store_data`: 0, provided no forwarding input matches (the stored rs number is 0).
  - `stall_id`: 0.
- Reset asserted mid-stall clears the stage; `stall_id` falls in the same cycle that `ex_valid` falls.
- Back-to-back loads feeding each other stall once per pair.

## Structure
- Shared package `cpu_pkg`:
  - `XLEN` and `RAW` constants.
  - ALU opcode constants: ADD=0, SLL=1, SLT=2, SLTU=3, XOR=4, SRL=5, OR=6, AND=7, SUB=8, SRA=13.
  - ID/EX field bundle typedef.
- One sub-module, `fwd_mux`: inputs are the source register number, stored data and both forwarding ports; output is the selected value with the priority above. It is instantiated twice (rs1, rs2).

## Test plan
- **Reset**: hold `rst` 2 cycles with random `id_*` inputs → all outputs 0, `ex_valid`=0.
- **EX/MEM forward**: `add x5` in EX/MEM (`exmem_result`=0x10) while EX holds `sub x6,x5,x5` with stored data 0x99 → `ex_in1`=`ex_in2`=0x10, `ex_alucon`=8.
- **Priority**: EX/MEM and MEM/WB both target x7 (0xAAAA / 0xBBBB) → EX/MEM value 0xAAAA wins. With rd=x0 on both ports → stored data passes.
- **Load-use**: `lw x3` in EX with `add x4,x3,x1` in ID → `stall_id`=1 for exactly 1 cycle, bubble enters EX. The `add` is then captured and forwards from MEM/WB.
- **Flush vs stall**: `flush`=1 and `stall_id`=1 in the same cycle → bubble, `ex_regwrite`=0. After flush → normal capture resumes.
- **Write-through**: MEM/WB writes x9=0x1234 while ID captures `addi x2,x9,4` with `id_rs1_data`=0 and `alusrc_b`=1, `id_imm`=4 → next cycle `ex_in1`=0x1234, `ex_in2`=4.
